// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory responder.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 illegal)
//   - responder FSM state enum (ST_ACC2 exists only with DMEM_MISALIGN_SPLIT_EN)
//   - lane-mask helper: unshifted byte-enable pattern for a given size
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACC,
`ifdef DMEM_MISALIGN_SPLIT_EN
    ST_ACC2,
`endif
    ST_RESP
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: lane_mask = LANE_MASK_BYTE;
      SZ_HALF: lane_mask = LANE_MASK_HALF;
      default: lane_mask = LANE_MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational byte-lane steering, shared by ACC and ACC2.
// Works on a two-word (64-bit) window so a split access uses the same path.
//   size        : access size encoding
//   is_unsigned : zero-extend loads instead of sign-extend
//   offset      : byte offset within the first word (addr[1:0])
//   wdata       : right-aligned store data
//   rdata       : {second word, first word} read window
//   byte_en     : store byte enables across the window (bits 3:0 first word)
//   wdata_lanes : store data shifted onto its lanes across the window
//   load_data   : extracted and extended load result
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  byte_en,
  output logic [63:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [5:0]  bit_shift;
  logic [31:0] picked;

  always_comb begin
    bit_shift   = {1'b0, offset, 3'b000};
    byte_en     = {4'b0000, lane_mask(size)} << offset;
    wdata_lanes = {32'h0, wdata} << bit_shift;
    picked      = 32'(rdata >> bit_shift);
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, picked[7:0]}
                                       : {{24{picked[7]}}, picked[7:0]};
      SZ_HALF: load_data = is_unsigned ? {16'h0, picked[15:0]}
                                       : {{16{picked[15]}}, picked[15:0]};
      default: load_data = picked;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder with programmable wait states in
// front of an internal byte-addressable word RAM.
//   clk, rst (async, active-high)
//   req_valid/req_ready, req_we, req_size, req_unsigned, req_addr, req_wdata
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
// Optional feature macro DMEM_MISALIGN_SPLIT_EN: misaligned in-range halves and
// words are split into two aligned word accesses (ACC then ACC2) instead of
// erroring.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS_LAST   = 4'(WAIT_STATES - 1);

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [3:0][7:0] ram [DEPTH_WORDS];

  // Request classification
  logic [1:0]  last_off;
  logic [32:0] last_byte;
  logic        misaligned;
  logic        req_err;

  always_comb begin
    case (req_size)
      SZ_BYTE: last_off = 2'd0;
      SZ_HALF: last_off = 2'd1;
      default: last_off = 2'd3;
    endcase
    last_byte  = {1'b0, req_addr} + {31'h0, last_off};
    misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    req_err    = (req_size == 2'b11) ||
                 ({1'b0, req_addr} >= MEM_BYTES) || (last_byte >= MEM_BYTES);
`ifndef DMEM_MISALIGN_SPLIT_EN
    req_err    = req_err || misaligned;
`endif
  end

  logic [AW-1:0] word_idx;
  logic [31:0]   ram_rd;
  logic [63:0]   lane_rdata;
  logic [7:0]    byte_en;
  logic [63:0]   wdata_lanes;
  logic [31:0]   load_data;

  assign word_idx = addr_q[AW+1:2];

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic          split_q;
  logic          second_q;
  logic [31:0]   lo_q;
  logic [AW-1:0] rd_idx;

  assign rd_idx     = (state == ST_ACC2) ? word_idx + AW'(1) : word_idx;
  assign ram_rd     = ram[rd_idx];
  assign lane_rdata = (state == ST_ACC2) ? {ram_rd, lo_q} : {32'h0, ram_rd};
`else
  logic unused_hi;

  assign ram_rd     = ram[word_idx];
  assign lane_rdata = {32'h0, ram_rd};
  assign unused_hi  = ^{byte_en[7:4], wdata_lanes[63:32]};
`endif

  dmem_lane_unit u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (lane_rdata),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data)
  );

  // RAM: per-byte enables, never reset. Writes only happen in ACC/ACC2, so an
  // asynchronous reset before the ACC edge leaves the RAM untouched.
  always_ff @(posedge clk) begin
    if (we_q && (state == ST_ACC)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[word_idx][i] <= wdata_lanes[8*i +: 8];
      end
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (we_q && (state == ST_ACC2)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[4+i]) ram[word_idx + AW'(1)][i] <= wdata_lanes[32+8*i +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      split_q   <= 1'b0;
      second_q  <= 1'b0;
      lo_q      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            addr_q    <= req_addr[AW+1:0];
            wdata_q   <= req_wdata;
            wait_cnt  <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            split_q   <= misaligned;
            second_q  <= 1'b0;
`endif
            if (req_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (WAIT_STATES == 0) begin
              state <= ST_ACC;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WS_LAST) begin
            wait_cnt <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            state    <= second_q ? ST_ACC2 : ST_ACC;
`else
            state    <= ST_ACC;
`endif
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_ACC: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
          if (split_q) begin
            // First word is kept so ACC2 can extract across the boundary.
            lo_q     <= ram_rd;
            second_q <= 1'b1;
            state    <= (WAIT_STATES == 0) ? ST_ACC2 : ST_WAIT;
          end else begin
            rsp_rdata <= we_q ? '0 : load_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
`else
          rsp_rdata <= we_q ? '0 : load_data;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
`endif
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        ST_ACC2: begin
          rsp_rdata <= we_q ? '0 : load_data;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: byte-array reference model,
// per-cycle output compare, directed cases plus randomized traffic.
// Works with and without DMEM_MISALIGN_SPLIT_EN.
module tb_data_mem_responder;

  localparam int unsigned W         = 1;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned MEM_BYTES = 4 * DEPTH;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mem_m [MEM_BYTES];

  logic        busy = 1'b0;
  logic        resp_seen = 1'b0;
  int          k = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          acc_cyc = 0;
  int          hs_cyc = 0;
  logic        m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        exp_err;
  int          exp_lat;
  logic [31:0] exp_rdata;
  int          last_k = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  task automatic model_accept(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr);
    int  nb;
    bit  mis;
    longint last;
    logic [31:0] val;
    nb   = nbytes(size);
    mis  = (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    last = longint'(addr) + nb - 1;
    exp_err = (size == 2'd3) || (longint'(addr) >= MEM_BYTES) ||
              (last >= MEM_BYTES) || (mis && !SPLIT);
    if (exp_err)   exp_lat = 1;
    else if (mis)  exp_lat = 3 + 2 * W;
    else           exp_lat = 2 + W;
    val = '0;
    if (!exp_err && !we) begin
      for (int i = 0; i < nb; i++) val[8*i +: 8] = mem_m[int'(addr) + i];
      if (!uns && size == 2'd0 && val[7])  val = val | 32'hFFFF_FF00;
      if (!uns && size == 2'd1 && val[15]) val = val | 32'hFFFF_0000;
    end
    exp_rdata = val;
  endtask

  task automatic model_commit();
    if (m_we && !exp_err)
      for (int i = 0; i < nbytes(m_size); i++) mem_m[int'(m_addr) + i] = m_wdata[8*i +: 8];
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy = 1'b0;
      resp_seen = 1'b0;
      chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'h0, rsp_err},   32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    end else if (!busy) begin
      chk("idle_req_ready", {31'h0, req_ready}, 32'd1);
      chk("idle_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      if (req_valid) begin
        m_we = req_we; m_size = req_size; m_addr = req_addr; m_wdata = req_wdata;
        model_accept(req_we, req_size, req_unsigned, req_addr);
        busy = 1'b1; k = 0; resp_seen = 1'b0;
        acc_cyc = cyc;
        acc_cnt++;
      end
    end else begin
      k++;
      chk("busy_req_ready", {31'h0, req_ready}, 32'd0);
      if (k < exp_lat) begin
        chk("early_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      end else begin
        chk("rsp_valid", {31'h0, rsp_valid}, 32'd1);
        chk("rsp_err",   {31'h0, rsp_err},   {31'h0, exp_err});
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        if (!resp_seen) begin
          resp_seen = 1'b1;
          last_k = k; last_err = rsp_err; last_rdata = rsp_rdata;
        end
        if (rsp_ready && rsp_valid) begin
          model_commit();
          busy = 1'b0;
          hs_cyc = cyc;
          done_cnt++;
        end
      end
      if (busy && k > exp_lat + 64) begin
        checks++; errors++;
        $display("FAIL rsp_timeout: no handshake after %0d cycles, expected latency %0d", k, exp_lat);
        busy = 1'b0;
        done_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  // All driver actions happen 1ns after a rising edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int c0;
    int n;
    c0 = acc_cnt;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (acc_cnt == c0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (acc_cnt == c0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: request at %h never accepted", a);
    end
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input int stall);
    int n;
    int c0;
    c0 = done_cnt - ((resp_seen && !busy) ? 1 : 0);
    n = 0;
    while (!resp_seen && busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (stall) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (busy || done_cnt == c0) begin
      checks++; errors++;
      $display("FAIL done_timeout: response handshake not observed");
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int stall);
    rsp_ready = (stall == 0);
    issue(we, sz, uns, a, wd);
    finish_rsp(stall);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // word store / load, latency 2+W
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    chk("st_word_lat", last_k, 32'd3);
    chk("st_word_rdata", last_rdata, 32'd0);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("ld_word", last_rdata, 32'hDEAD_BEEF);
    chk("ld_word_lat", last_k, 32'd3);
    chk("ld_word_err", {31'h0, last_err}, 32'd0);

    // sub-word
    xact(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, 0);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("ld_word_after_sh", last_rdata, 32'h1234_BEEF);
    xact(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);
    chk("lb_signed", last_rdata, 32'hFFFF_FFBE);
    xact(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0);
    chk("lbu", last_rdata, 32'h0000_00BE);
    xact(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
    chk("lh", last_rdata, 32'h0000_1234);

    // misaligned word load
    xact(1'b1, 2'd2, 1'b0, 32'h14, 32'h0000_0055, 0);
    xact(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0);
    if (SPLIT) begin
      chk("mis_ld_split", last_rdata, 32'h5512_34BE);
      chk("mis_ld_split_lat", last_k, 32'd5);
    end else begin
      chk("mis_ld_err", {31'h0, last_err}, 32'd1);
      chk("mis_ld_err_rdata", last_rdata, 32'd0);
      chk("mis_ld_err_lat", last_k, 32'd1);
    end

    // out-of-range and illegal size
    xact(1'b1, 2'd2, 1'b0, MEM_BYTES - 4, 32'hCAFE_F00D, 0);
    xact(1'b1, 2'd2, 1'b0, MEM_BYTES, 32'h1234_5678, 0);
    chk("oor_store_err", {31'h0, last_err}, 32'd1);
    chk("oor_store_lat", last_k, 32'd1);
    xact(1'b0, 2'd2, 1'b0, MEM_BYTES - 4, 32'h0, 0);
    chk("last_word_intact", last_rdata, 32'hCAFE_F00D);
    xact(1'b0, 2'd1, 1'b0, MEM_BYTES - 1, 32'h0, 0);
    chk("half_crossing_end_err", {31'h0, last_err}, 32'd1);
    xact(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
    chk("size11_err", {31'h0, last_err}, 32'd1);

    // backpressure, then back-to-back acceptance
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3);
    chk("bp_rdata", last_rdata, 32'h1234_BEEF);
    issue(1'b0, 2'd0, 1'b1, 32'h14, 32'h0);
    chk("next_accept_gap", acc_cyc - hs_cyc, 32'd1);
    finish_rsp(0);
    chk("after_bp_lbu", last_rdata, 32'h0000_0055);

    // reset during WAIT of a store
    xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h1357_9BDF, 0);
    rsp_ready = 1'b1;
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hAAAA_AAAA);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    chk("abort_keeps_old", last_rdata, 32'h1357_9BDF);

    // preload regions used by random traffic
    for (int a = 0; a < 'h88; a += 4) xact(1'b1, 2'd2, 1'b0, a, $urandom, 0);
    xact(1'b1, 2'd2, 1'b0, MEM_BYTES - 8, $urandom, 0);
    xact(1'b1, 2'd2, 1'b0, MEM_BYTES - 4, $urandom, 0);

    // randomized traffic, checked by the compare process every cycle
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = ($urandom_range(0, 9) == 0) ? $urandom_range(MEM_BYTES - 8, MEM_BYTES + 4)
                                       : $urandom_range(0, 'h7F);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
           $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
